// File: rtl/pool_ctrl_pkg.sv
// Shared types and sizing helpers for the max-pool sequencer.
package pool_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } pool_state_t;

  // Number of pooled outputs per row (stride equals the kernel size).
  function automatic int out_width(input int img_width, input int kernel_dim);
    return img_width / kernel_dim;
  endfunction

  // Bit width needed to hold 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pool_pos_counter.sv
// Paired wrap counter: image position 0..COUNT-1 and kernel phase 0..PHASE-1,
// both stepping together on i_en. Used once for columns and once for rows.
module pool_pos_counter
  import pool_ctrl_pkg::*;
#(
  parameter int COUNT = 22,
  parameter int PHASE = 2,
  parameter int POS_W = clog2_min1(COUNT),
  parameter int PH_W  = clog2_min1(PHASE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [POS_W-1:0] o_pos,
  output logic [PH_W-1:0]  o_phase,
  output logic             o_wrap,
  output logic             o_phase_last
);

  logic [POS_W-1:0] r_pos;
  logic [PH_W-1:0]  r_phase;
  logic             w_pos_last;
  logic             w_ph_last;

  assign w_pos_last = (r_pos == POS_W'(COUNT - 1));
  assign w_ph_last  = (r_phase == PH_W'(PHASE - 1));

  // Advance position and phase on enable; clear has priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pos   <= '0;
      r_phase <= '0;
    end else if (i_clr) begin
      r_pos   <= '0;
      r_phase <= '0;
    end else if (i_en) begin
      r_pos   <= w_pos_last ? '0 : r_pos + 1'b1;
      r_phase <= w_ph_last  ? '0 : r_phase + 1'b1;
    end
  end

  assign o_pos        = r_pos;
  assign o_phase      = r_phase;
  assign o_wrap       = i_en && w_pos_last;
  assign o_phase_last = w_ph_last;

endmodule

// File: rtl/pool_ctrl.sv
// Max-pool layer sequencer: accepts pixels, tracks the image position and
// issues one function-start pulse per completed non-overlapping window.
module pool_ctrl
  import pool_ctrl_pkg::*;
#(
  parameter int IMG_WIDTH  = 22,
  parameter int KERNEL_DIM = 2,
  parameter int OUT_W      = out_width(IMG_WIDTH, KERNEL_DIM),
  parameter int POS_W      = clog2_min1(IMG_WIDTH),
  parameter int WIN_W      = clog2_min1(OUT_W * OUT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_data_valid,
  output logic             o_ready,
  output logic             o_ibuf_we,
  input  logic             i_next_busy,
  output logic             o_func_start,
  output logic [WIN_W-1:0] o_win_idx,
  output logic             o_busy,
  output logic             o_done
);

  localparam int PH_W = clog2_min1(KERNEL_DIM);

  generate
    if ((IMG_WIDTH % KERNEL_DIM) != 0) begin : g_bad_cfg
      $error("pool_ctrl: IMG_WIDTH must be a multiple of KERNEL_DIM");
    end
  endgenerate

  pool_state_t      r_state;
  pool_state_t      w_state_next;
  logic [WIN_W-1:0] r_win_idx;
  logic             r_last_win;

  logic             w_clr;
  logic             w_accept;
  logic             w_fire;
  logic             w_win_done;
  logic             w_col_wrap;
  logic             w_row_wrap;
  logic             w_col_ph_last;
  logic             w_row_ph_last;
  logic [POS_W-1:0] w_col_pos;
  logic [POS_W-1:0] w_row_pos;
  logic [PH_W-1:0]  w_col_phase;
  logic [PH_W-1:0]  w_row_phase;

  assign w_clr      = (r_state == IDLE) && i_start;
  assign w_accept   = (r_state == FILL) && i_data_valid;
  assign w_fire     = (r_state == EMIT) && !i_next_busy;
  assign w_win_done = w_accept && w_col_ph_last && w_row_ph_last;

  pool_pos_counter #(
    .COUNT (IMG_WIDTH),
    .PHASE (KERNEL_DIM),
    .POS_W (POS_W),
    .PH_W  (PH_W)
  ) u_col (
    .clk          (clk),
    .rst          (rst),
    .i_en         (w_accept),
    .i_clr        (w_clr),
    .o_pos        (w_col_pos),
    .o_phase      (w_col_phase),
    .o_wrap       (w_col_wrap),
    .o_phase_last (w_col_ph_last)
  );

  // Row counter steps only when the column counter wraps.
  pool_pos_counter #(
    .COUNT (IMG_WIDTH),
    .PHASE (KERNEL_DIM),
    .POS_W (POS_W),
    .PH_W  (PH_W)
  ) u_row (
    .clk          (clk),
    .rst          (rst),
    .i_en         (w_col_wrap),
    .i_clr        (w_clr),
    .o_pos        (w_row_pos),
    .o_phase      (w_row_phase),
    .o_wrap       (w_row_wrap),
    .o_phase_last (w_row_ph_last)
  );

  // Phase values and the frame wrap are carried by the counters but only the
  // phase-last flags and positions steer the sequencer.
  logic w_unused;
  assign w_unused = ^{w_col_phase, w_row_phase, w_row_wrap};

  // State register, window index and the "this window ends the frame" flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_win_idx  <= '0;
      r_last_win <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_clr) begin
        r_win_idx  <= '0;
        r_last_win <= 1'b0;
      end else begin
        if (w_fire) begin
          r_win_idx <= r_win_idx + 1'b1;
        end
        if (w_win_done) begin
          r_last_win <= (w_col_pos == POS_W'(IMG_WIDTH - 1)) &&
                        (w_row_pos == POS_W'(IMG_WIDTH - 1));
        end
      end
    end
  end

  // Next-state and output decode; outputs are combinational from the state.
  always_comb begin
    w_state_next = r_state;
    o_ready      = 1'b0;
    o_ibuf_we    = 1'b0;
    o_func_start = 1'b0;
    o_win_idx    = '0;
    o_busy       = (r_state != IDLE);
    o_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) w_state_next = FILL;
      end
      FILL: begin
        o_ready   = 1'b1;
        o_ibuf_we = i_data_valid;
        if (w_win_done) w_state_next = EMIT;
      end
      EMIT: begin
        if (!i_next_busy) begin
          o_func_start = 1'b1;
          o_win_idx    = r_win_idx;
          w_state_next = r_last_win ? DONE : FILL;
        end
      end
      DONE: begin
        o_done       = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

endmodule

// File: doc/pool_ctrl.md
# pool_ctrl

Sequencer for the max-pool layer datapath. Accepts one pixel per cycle from the upstream layer, shared across all channels. Drives the common input-buffer write enable. Tracks image position and fires a function-start pulse to the downstream layer whenever a complete non-overlapping kernel window (stride = kernel_dim) sits in the line buffers. It stalls upstream while the downstream layer is busy, and signals frame completion.

## Interface
- img_width, 22: input image width and height (square image); must be divisible by kernel_dim, enforced by an elaboration assertion
- kernel_dim, 2: pooling window N (NxN), also the stride
- Derived: out_width = img_width/kernel_dim; POS_W = $clog2(img_width); WIN_W = $clog2(out_width**2)
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- i_start  in  1  frame-start pulse; honoured only in IDLE
- i_data_valid  in  1  upstream pixel present on all channels this cycle
- o_ready  out  1  controller accepts a pixel this cycle; reset 0
- o_ibuf_we  out  1  write enable to every channel's input buffer = i_data_valid & o_ready; reset 0
- i_next_busy  in  1  downstream layer cannot take a result
- o_func_start  out  1  one-cycle pulse: pooled window valid at datapath output; reset 0
- o_win_idx  out  WIN_W  raster index of the window, valid with o_func_start; reset 0
- o_busy  out  1  high in every state except IDLE; reset 0
- o_done  out  1  one-cycle pulse at end of frame; reset 0

## Operation
- States: IDLE, FILL, EMIT, DONE.
- IDLE
  - o_ready=0.
  - i_start → FILL; clears col, row, kcol, krow and win_idx.
- FILL
  - o_ready=1. On accept (i_data_valid):
    - col increments and wraps at img_width-1 → 0, with row++.
    - kcol increments and wraps at kernel_dim-1, in lockstep with col. krow is the same for row, advancing on col wrap.
  - If the accepted pixel has kcol==kernel_dim-1 and krow==kernel_dim-1 → EMIT.
  - No accept → stay in FILL; counters hold.
- EMIT
  - o_ready=0, so the buffers do not shift and the window is stable.
  - If !i_next_busy: o_func_start=1 and o_win_idx=win_idx this cycle. win_idx then increments.
    - Next state is DONE if this was the window ending at pixel (img_width-1, img_width-1), else FILL.
  - If i_next_busy: stay in EMIT with o_func_start=0. Wait is indefinite.
- DONE
  - o_done=1 for one cycle → IDLE. Counters are cleared on the next i_start.
- Pixels on non-window positions (including trailing partial strides) only advance counters.
- i_start outside IDLE is ignored. i_data_valid outside FILL is not accepted and not written.
- Reset asserted mid-frame: immediate return to IDLE, all outputs 0, all counters 0. The partial frame is discarded, with no o_done.

## Timing
- Window-completing pixel accepted at edge N. EMIT occupies cycle N+1 and o_func_start is high in that cycle if i_next_busy=0. The datapath output is combinational from the buffers and valid in the same cycle.
- Each window costs one stall cycle on o_ready, plus one cycle per cycle of i_next_busy.
- Best-case frame: img_width² + out_width² cycles of o_ready/EMIT, +1 cycle DONE, measured from the first FILL cycle.
- i_next_busy is sampled only in EMIT. Its deassertion takes effect the same cycle (no registering).
- o_ibuf_we is combinational: no write occurs in IDLE, EMIT or DONE, regardless of i_data_valid.

## Structure
- Package pool_ctrl_pkg:
  - typedef enum logic [1:0] pool_state_t {IDLE, FILL, EMIT, DONE}
  - function for out_width
- One sub-module is natural: pool_pos_counter, a paired wrap counter (position 0..img_width-1, phase 0..kernel_dim-1) with enable, clear and wrap outputs. It is instantiated once for columns and once for rows; the row instance is enabled by column wrap.
- win_idx and the FSM live in pool_ctrl. No datapath logic lives in pool_ctrl.

## Test plan
- img_width=4, kernel_dim=2, i_data_valid always 1, i_next_busy=0, 16 pixels → o_func_start after accepts of 0-based pixels 5, 7, 13, 15, with o_win_idx 0, 1, 2, 3; o_done one cycle after the 4th pulse; total 21 cycles from the first FILL cycle.
- Same config, i_next_busy held 3 cycles during the second EMIT → o_ready=0 and o_ibuf_we=0 for 4 cycles, one o_func_start with o_win_idx=1, later windows unchanged.
- Same config, i_data_valid toggled 1/0 every cycle → counters advance only on accepts; pulse pattern and indices identical to the first test.
- i_start asserted in FILL and EMIT → ignored, state unaffected; i_data_valid in IDLE → o_ibuf_we=0.
- rst low at pixel 9 → all outputs 0 immediately, no o_done. New i_start with 16 pixels → index sequence restarts at 0.
- img_width=6, kernel_dim=3, 36 pixels → 4 pulses after pixels 14, 17, 32, 35.
